// File: rtl/mem_access_pkg.sv
// Shared types and lane constants for the memory-stage load/store unit.
package mem_access_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NumLanes = XLEN / 8;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } mau_state_e;

  localparam logic [NumLanes-1:0] BeByte0  = 4'b0001;
  localparam logic [NumLanes-1:0] BeLoHalf = 4'b0011;
  localparam logic [NumLanes-1:0] BeHiHalf = 4'b1100;
  localparam logic [NumLanes-1:0] BeAll    = 4'b1111;

  // Reserved type counts as misaligned so it is dropped with the same pulse.
  function automatic logic is_misaligned(mem_type_e t, logic [1:0] off);
    logic mis;
    unique case (t)
      MEM_BYTE: mis = 1'b0;
      MEM_HALF: mis = off[0];
      MEM_WORD: mis = (off != 2'b00);
      MEM_RSVD: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: store byte enables and replication, load realign and extend,
// plus misaligned/reserved access detection.
module load_store_align
  import mem_access_pkg::*;
(
  input  logic [1:0]          st_off_i,
  input  mem_type_e           st_type_i,
  input  logic [XLEN-1:0]     st_data_i,
  output logic [NumLanes-1:0] st_be_o,
  output logic [XLEN-1:0]     st_wdata_o,
  output logic                misaligned_o,

  input  logic [1:0]          ld_off_i,
  input  mem_type_e           ld_type_i,
  input  logic                ld_sign_i,
  input  logic [XLEN-1:0]     ld_rdata_i,
  output logic [XLEN-1:0]     ld_data_o
);

  logic [XLEN-1:0] shifted;

  assign misaligned_o = is_misaligned(st_type_i, st_off_i);

  always_comb begin
    st_be_o    = BeAll;
    st_wdata_o = st_data_i;
    unique case (st_type_i)
      MEM_BYTE: begin
        st_be_o    = BeByte0 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      MEM_HALF: begin
        st_be_o    = st_off_i[1] ? BeHiHalf : BeLoHalf;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      MEM_WORD: begin
        st_be_o    = BeAll;
        st_wdata_o = st_data_i;
      end
      MEM_RSVD: begin
        st_be_o    = '0;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  assign shifted = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = shifted;
    unique case (ld_type_i)
      MEM_BYTE: ld_data_o = {{24{ld_sign_i & shifted[7]}}, shifted[7:0]};
      MEM_HALF: ld_data_o = {{16{ld_sign_i & shifted[15]}}, shifted[15:0]};
      MEM_WORD: ld_data_o = shifted;
      MEM_RSVD: ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: one req/gnt/rvalid transaction per instruction, holding the
// upstream stages via stall_o while the access is in flight.
module memory_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_WIDTH             = 32,
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              memWriteE_i,
  input  logic                              resultSRCE_i,
  input  logic [DATA_WIDTH-1:0]             ALUresultE_i,
  input  logic [DATA_WIDTH-1:0]             RD2E_i,
  input  logic [1:0]                        memTypeE_i,
  input  logic                              memSignE_i,
  input  logic                              regWriteE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] AD3E_i,
  output logic                              memReq_o,
  output logic                              memWe_o,
  output logic [DATA_WIDTH-1:0]             memAddr_o,
  output logic [DATA_WIDTH-1:0]             memWData_o,
  output logic [3:0]                        memBe_o,
  input  logic                              memGnt_i,
  input  logic                              memRValid_i,
  input  logic [DATA_WIDTH-1:0]             memRData_i,
  output logic                              stall_o,
  output logic                              wbValidM_o,
  output logic                              regWriteM_o,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] AD3M_o,
  output logic [DATA_WIDTH-1:0]             readDataM_o,
  output logic                              misaligned_o
);

  mau_state_e                        state_q, state_d;
  logic [DATA_WIDTH-1:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]             wdata_q, wdata_d;
  logic [3:0]                        be_q, be_d;
  logic                              we_q, we_d;
  mem_type_e                         type_q, type_d;
  logic                              sign_q, sign_d;
  logic                              regwrite_q, regwrite_d;
  logic [REGISTER_ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
  logic                              req_q, req_d;
  logic [DATA_WIDTH-1:0]             rdata_q, rdata_d;

  logic                  access;
  logic                  mis;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [DATA_WIDTH-1:0] ld_data;

  assign access = memWriteE_i | resultSRCE_i;

  load_store_align u_align (
    .st_off_i     (ALUresultE_i[1:0]),
    .st_type_i    (mem_type_e'(memTypeE_i)),
    .st_data_i    (RD2E_i),
    .st_be_o      (st_be),
    .st_wdata_o   (st_wdata),
    .misaligned_o (mis),
    .ld_off_i     (addr_q[1:0]),
    .ld_type_i    (type_q),
    .ld_sign_i    (sign_q),
    .ld_rdata_i   (memRData_i),
    .ld_data_o    (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    type_d       = type_q;
    sign_d       = sign_q;
    regwrite_d   = regwrite_q;
    ad3_d        = ad3_q;
    req_d        = req_q;
    rdata_d      = rdata_q;
    stall_o      = 1'b0;
    misaligned_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (access && mis) begin
          misaligned_o = 1'b1;
        end else if (access) begin
          stall_o    = 1'b1;
          addr_d     = ALUresultE_i;
          wdata_d    = st_wdata;
          be_d       = st_be;
          // A store wins when both store and load flags are set.
          we_d       = memWriteE_i;
          type_d     = mem_type_e'(memTypeE_i);
          sign_d     = memSignE_i;
          regwrite_d = regWriteE_i;
          ad3_d      = AD3E_i;
          rdata_d    = '0;
          req_d      = 1'b1;
          state_d    = StReq;
        end
      end
      StReq: begin
        stall_o = 1'b1;
        if (memGnt_i) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = StDone;
          end else if (memRValid_i) begin
            rdata_d = ld_data;
            state_d = StDone;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        stall_o = 1'b1;
        if (memRValid_i) begin
          rdata_d = ld_data;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      type_q     <= MEM_BYTE;
      sign_q     <= 1'b0;
      regwrite_q <= 1'b0;
      ad3_q      <= '0;
      req_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      type_q     <= type_d;
      sign_q     <= sign_d;
      regwrite_q <= regwrite_d;
      ad3_q      <= ad3_d;
      req_q      <= req_d;
      rdata_q    <= rdata_d;
    end
  end

  assign memReq_o    = req_q;
  assign memWe_o     = we_q;
  assign memAddr_o   = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign memWData_o  = wdata_q;
  assign memBe_o     = be_q;
  assign wbValidM_o  = (state_q == StDone);
  assign regWriteM_o = wbValidM_o & regwrite_q;
  assign AD3M_o      = ad3_q;
  assign readDataM_o = rdata_q;

  req_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
    memReq_o && !memGnt_i |=> memReq_o && $stable(memAddr_o));
  wb_pulse_a: assert property (@(posedge clk) disable iff (!rst_n)
    wbValidM_o |=> !wbValidM_o);
  mis_drop_a: assert property (@(posedge clk) disable iff (!rst_n)
    misaligned_o |-> !stall_o && !memReq_o);

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench: driver pushes bus/writeback expectations from a byte-addressed memory model,
// a bus responder and a writeback monitor pop and compare.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memWriteE, resultSRCE, memSignE, regWriteE;
  logic [31:0] ALUresultE, RD2E;
  logic [1:0]  memTypeE;
  logic [4:0]  AD3E;
  logic        memReq, memWe, memGnt, memRValid;
  logic [31:0] memAddr, memWData, memRData;
  logic [3:0]  memBe;
  logic        stall, wbValid, regWriteM, misaligned;
  logic [4:0]  AD3M;
  logic [31:0] readDataM;

  memory_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .memWriteE_i  (memWriteE),
    .resultSRCE_i (resultSRCE),
    .ALUresultE_i (ALUresultE),
    .RD2E_i       (RD2E),
    .memTypeE_i   (memTypeE),
    .memSignE_i   (memSignE),
    .regWriteE_i  (regWriteE),
    .AD3E_i       (AD3E),
    .memReq_o     (memReq),
    .memWe_o      (memWe),
    .memAddr_o    (memAddr),
    .memWData_o   (memWData),
    .memBe_o      (memBe),
    .memGnt_i     (memGnt),
    .memRValid_i  (memRValid),
    .memRData_i   (memRData),
    .stall_o      (stall),
    .wbValidM_o   (wbValid),
    .regWriteM_o  (regWriteM),
    .AD3M_o       (AD3M),
    .readDataM_o  (readDataM),
    .misaligned_o (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        rw;
    logic [4:0]  ad3;
    logic [31:0] data;
  } wb_exp_t;

  bus_exp_t    bus_q[$];
  wb_exp_t     wb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          gnt_dly = 0;
  int          rv_dly = 0;
  bit          rv_same = 0;
  bit          mis_expected = 0;
  logic [31:0] bus_mem [64];
  logic [7:0]  ref_mem [256];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(logic [1:0] t);
    return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_mis(logic [1:0] t, logic [31:0] a);
    return (t == 2'd3) || (t == 2'd1 && a[0]) || (t == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, logic [1:0] t, logic s);
    logic [31:0] v;
    int          nb;
    int          base;
    nb   = nbytes(t);
    base = int'(a - 32'h100);
    v    = '0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[base + k];
    if (s && nb < 4 && v[8*nb-1]) begin
      for (int k = 8 * nb; k < 32; k++) v[k] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_be(logic [1:0] t, logic [1:0] off);
    case (t)
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(logic [1:0] t, logic [31:0] d);
    case (t)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  task automatic ref_store(logic [31:0] a, logic [1:0] t, logic [31:0] d);
    int base;
    base = int'(a - 32'h100);
    for (int k = 0; k < nbytes(t); k++) ref_mem[base + k] = d[8*k +: 8];
  endtask

  task automatic preload(logic [31:0] a, logic [31:0] w);
    bus_mem[(a - 32'h100) >> 2] = w;
    for (int k = 0; k < 4; k++) ref_mem[int'(a - 32'h100) + k] = w[8*k +: 8];
  endtask

  task automatic clear_inputs();
    memWriteE  = 1'b0;
    resultSRCE = 1'b0;
    ALUresultE = '0;
    RD2E       = '0;
    memTypeE   = '0;
    memSignE   = 1'b0;
    regWriteE  = 1'b0;
    AD3E       = '0;
  endtask

  // Called just after a posedge; returns just after the posedge that retires the instruction.
  task automatic issue(logic we, logic ld, logic [1:0] t, logic s, logic [31:0] a,
                       logic [31:0] d, logic rw, logic [4:0] rd, int gd, bit rs, int rvd);
    bus_exp_t b;
    wb_exp_t  w;
    bit       mis;
    bit       done;
    int       lat;
    mis     = ref_mis(t, a);
    gnt_dly = gd;
    rv_same = rs;
    rv_dly  = rvd;
    lat     = 0;
    if (!mis) begin
      b.we    = we;
      b.addr  = {a[31:2], 2'b00};
      b.be    = exp_be(t, a[1:0]);
      b.wdata = exp_wdata(t, d);
      w.rw    = rw;
      w.ad3   = rd;
      if (we) begin
        w.data = '0;
        ref_store(a, t, d);
      end else begin
        w.data = ref_load(a, t, s);
      end
      bus_q.push_back(b);
      wb_q.push_back(w);
      lat = 2 + gd + ((we || rs) ? 0 : rvd + 1);
    end
    mis_expected = mis;
    memWriteE  = we;
    resultSRCE = ld;
    ALUresultE = a;
    RD2E       = d;
    memTypeE   = t;
    memSignE   = s;
    regWriteE  = rw;
    AD3E       = rd;
    if (mis) begin
      @(negedge clk);
      check("mis_pulse", misaligned, 1);
      check("mis_stall", stall, 0);
      check("mis_req", memReq, 0);
      @(posedge clk); #1;
      clear_inputs();
      mis_expected = 0;
      @(negedge clk);
      check("mis_req_after", memReq, 0);
      @(posedge clk); #1;
    end else begin
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        if (wbValid) begin
          check("latency", c, lat);
          done = 1;
        end else begin
          check("stall_busy", stall, 1);
        end
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL wb_timeout: got no wbValid expected one within 200 cycles");
      end
      @(posedge clk); #1;
      clear_inputs();
    end
  endtask

  initial begin : responder
    bus_exp_t    e;
    logic [31:0] a0;
    int          idx;
    memGnt    = 1'b0;
    memRValid = 1'b0;
    memRData  = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || memReq !== 1'b1) continue;
      a0  = memAddr;
      idx = int'((a0 - 32'h100) >> 2);
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got request at 0x%08h expected none", a0);
        e.we = memWe;
      end else begin
        e = bus_q.pop_front();
        check("bus_addr", memAddr, e.addr);
        check("bus_we", memWe, e.we);
        if (e.we) begin
          check("bus_be", memBe, e.be);
          check("bus_wdata", memWData, e.wdata);
        end
      end
      for (int k = 0; k < gnt_dly; k++) begin
        @(negedge clk);
        check("req_held", memReq, 1);
        check("addr_held", memAddr, a0);
      end
      if (idx < 0 || idx > 63) idx = 0;
      memGnt = 1'b1;
      if (memWe) begin
        for (int k = 0; k < 4; k++)
          if (memBe[k]) bus_mem[idx][8*k +: 8] = memWData[8*k +: 8];
      end else if (rv_same) begin
        memRValid = 1'b1;
        memRData  = bus_mem[idx];
      end
      @(posedge clk); #1;
      memGnt    = 1'b0;
      memRValid = 1'b0;
      memRData  = $urandom;
      if (!e.we && !rv_same) begin
        for (int k = 0; k < rv_dly; k++) @(negedge clk);
        @(negedge clk);
        memRValid = 1'b1;
        memRData  = bus_mem[idx];
        @(posedge clk); #1;
        memRValid = 1'b0;
        memRData  = $urandom;
      end
    end
  end

  initial begin : monitor
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (wbValid) begin
          if (wb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wb: got wbValid=1 expected 0 (rd %0d)", AD3M);
          end else begin
            e = wb_q.pop_front();
            check("wb_regwrite", regWriteM, e.rw);
            check("wb_ad3", AD3M, e.ad3);
            check("wb_data", readDataM, e.data);
            check("wb_stall", stall, 0);
          end
        end
        if (misaligned && !mis_expected) begin
          checks++;
          errors++;
          $display("FAIL spurious_mis: got misaligned=1 expected 0");
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected end within 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic        we, ld, s, rw;
    logic [1:0]  t;
    logic [31:0] a, d;
    int          r;
    clear_inputs();
    for (int i = 0; i < 64; i++) preload(32'h100 + 32'(4 * i), $urandom);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", memReq, 0);
    check("rst_we", memWe, 0);
    check("rst_addr", memAddr, 0);
    check("rst_wdata", memWData, 0);
    check("rst_be", memBe, 0);
    check("rst_stall", stall, 0);
    check("rst_wb", wbValid, 0);
    check("rst_regwrite", regWriteM, 0);
    check("rst_ad3", AD3M, 0);
    check("rst_rdata", readDataM, 0);
    check("rst_mis", misaligned, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LH signed, SB lane steering, LBU with split and same-cycle rvalid.
    preload(32'h100, 32'h8001_1234);
    issue(0, 1, 2'd1, 1, 32'h102, 32'h0, 1, 5'd7, 0, 0, 0);
    issue(1, 0, 2'd0, 0, 32'h103, 32'h0000_00AB, 0, 5'd0, 0, 0, 0);
    preload(32'h100, 32'h0000_F500);
    issue(0, 1, 2'd0, 0, 32'h101, 32'h0, 1, 5'd9, 0, 0, 0);
    issue(0, 1, 2'd0, 0, 32'h101, 32'h0, 1, 5'd10, 0, 1, 0);
    // Misaligned and reserved accesses are dropped.
    issue(0, 1, 2'd2, 0, 32'h102, 32'h0, 1, 5'd3, 0, 0, 0);
    issue(1, 0, 2'd3, 0, 32'h100, 32'h1, 1, 5'd4, 0, 0, 0);
    issue(1, 1, 2'd1, 0, 32'h105, 32'h1, 0, 5'd5, 0, 0, 0);
    // Slow grant and slow read data.
    preload(32'h140, 32'hCAFE_F00D);
    issue(0, 1, 2'd2, 0, 32'h140, 32'h0, 1, 5'd11, 5, 0, 3);
    // Both flags high behaves as a store.
    issue(1, 1, 2'd1, 1, 32'h146, 32'h0000_9876, 1, 5'd12, 1, 0, 0);
    issue(0, 1, 2'd1, 1, 32'h146, 32'h0, 1, 5'd13, 0, 0, 1);

    // Reset while waiting for read data; the late rvalid must be ignored.
    gnt_dly = 0;
    rv_same = 0;
    rv_dly  = 10;
    bus_q.push_back('{we: 1'b0, addr: 32'h180, be: 4'b1111, wdata: 32'h0});
    memWriteE  = 1'b0;
    resultSRCE = 1'b1;
    ALUresultE = 32'h180;
    memTypeE   = 2'd2;
    regWriteE  = 1'b1;
    AD3E       = 5'd21;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check("abort_req", memReq, 0);
    check("abort_stall", stall, 0);
    check("abort_wb", wbValid, 0);
    check("abort_addr", memAddr, 0);
    check("abort_ad3", AD3M, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_idle_stall", stall, 0);
    check("abort_rdata", readDataM, 0);
    @(posedge clk); #1;

    // Back-to-back SW then LW to the same word.
    issue(1, 0, 2'd2, 0, 32'h120, 32'hDEAD_BEEF, 0, 5'd1, 0, 0, 0);
    issue(0, 1, 2'd2, 0, 32'h120, 32'h0, 1, 5'd2, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 2);
      we = (r != 1);
      ld = (r != 0);
      r  = $urandom_range(0, 9);
      t  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = 32'h100 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (t == 2'd1) a[0] = 1'b0;
        if (t == 2'd2) a[1:0] = 2'b00;
      end
      d  = $urandom;
      s  = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      issue(we, ld, t, s, a, d, rw, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    if (wb_q.size() != 0 || bus_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d wb and %0d bus pending expected 0", wb_q.size(),
               bus_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
